// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame parameters.
// The transmitter is expected to reuse these.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_e;

  localparam int DEF_DBIT    = 8;
  localparam int DEF_SB_TICK = 16;
  localparam int DEF_OS_RATE = 16;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// Both flops reset to RST_VAL so the output does not glitch out of reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_amisha.sv
// Oversampling UART receiver: samples mid-bit on the baud tick, shifts LSB first,
// and reports each completed frame with a one-clock done pulse and stop-bit error flag.
module uart_rx_amisha
  import uart_pkg::*;
#(
  parameter int DBIT    = DEF_DBIT,
  parameter int SB_TICK = DEF_SB_TICK,
  parameter int OS_RATE = DEF_OS_RATE
) (
  input  logic            clk_amisha,
  input  logic            reset_amisha,
  input  logic            s_tick_amisha,
  input  logic            rx_amisha,
  output logic [DBIT-1:0] dout_amisha,
  output logic            rx_done_tick_amisha,
  output logic            frame_err_amisha
);

  localparam int SW = $clog2(imax(OS_RATE, SB_TICK));
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_MID  = SW'(OS_RATE / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OS_RATE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  // Whole FSM context in one struct so a checker can bind to regs_q.state directly.
  // armed: line has been seen high since the last frame; a held break cannot retrigger.
  typedef struct packed {
    uart_state_e     state;
    logic [SW-1:0]   s;
    logic [NW-1:0]   n;
    logic [DBIT-1:0] b;
    logic            armed;
  } rx_regs_t;

  rx_regs_t        regs_q, regs_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            rx_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk_i (clk_amisha),
    .rst_i (reset_amisha),
    .d_i   (rx_amisha),
    .q_o   (rx_s)
  );

  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) begin
      regs_q.state <= IDLE;
      regs_q.s     <= '0;
      regs_q.n     <= '0;
      regs_q.b     <= '0;
      regs_q.armed <= 1'b1;
      dout_q       <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      regs_q <= regs_d;
      dout_q <= dout_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    regs_d = regs_q;
    dout_d = dout_q;
    done_d = 1'b0;
    err_d  = 1'b0;
    if (rx_s) regs_d.armed = 1'b1;
    unique case (regs_q.state)
      IDLE: begin
        if (!rx_s && regs_q.armed) begin
          regs_d.state = START;
          regs_d.s     = '0;
        end
      end
      START: begin
        if (s_tick_amisha) begin
          if (regs_q.s == S_MID) begin
            if (!rx_s) begin
              regs_d.state = DATA;
              regs_d.s     = '0;
              regs_d.n     = '0;
            end else begin
              regs_d.state = IDLE;
            end
          end else begin
            regs_d.s = regs_q.s + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick_amisha) begin
          if (regs_q.s == S_BIT) begin
            regs_d.b = DBIT'({rx_s, regs_q.b} >> 1);
            regs_d.s = '0;
            if (regs_q.n == N_LAST) regs_d.state = STOP;
            else                    regs_d.n     = regs_q.n + 1'b1;
          end else begin
            regs_d.s = regs_q.s + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick_amisha) begin
          if (regs_q.s == S_STOP) begin
            regs_d.state = IDLE;
            regs_d.armed = rx_s;
            dout_d       = regs_q.b;
            done_d       = 1'b1;
            err_d        = !rx_s;
          end else begin
            regs_d.s = regs_q.s + 1'b1;
          end
        end
      end
      default: regs_d.state = IDLE;
    endcase
  end

  // done/err are single-clock pulses; dout is valid from the done clock until the next one.
  assign dout_amisha         = dout_q;
  assign rx_done_tick_amisha = done_q;
  assign frame_err_amisha    = err_q;

endmodule

// File: tb/tb_uart_rx_amisha.sv
// Directed plus randomized frames against a byte/stop-bit reference model; a mod-16
// counter supplies the oversample tick unless it is forced high every clock.
module tb_uart_rx_amisha;

  localparam int OS = 16;
  // Start detect: 2 sync clocks + 1 IDLE clock, then OS/2 start ticks,
  // 8*OS data ticks and OS stop ticks, all at one tick per clock.
  localparam int LAT = 2 + 1 + OS / 2 + 8 * OS + OS;

  logic       clk = 1'b0;
  logic       rst;
  logic       s_tick;
  logic       rx;
  logic [7:0] dout;
  logic       done;
  logic       ferr;
  logic [3:0] cnt_q = 4'd0;
  logic       tick_force = 1'b0;

  logic [8:0] exp_q[$];
  logic [7:0] last_dout = 8'h00;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #50 clk = ~clk;

  always @(posedge clk) cnt_q <= cnt_q + 4'd1;
  assign s_tick = tick_force | (cnt_q == 4'd15);

  uart_rx_amisha dut (
    .clk_amisha          (clk),
    .reset_amisha        (rst),
    .s_tick_amisha       (s_tick),
    .rx_amisha           (rx),
    .dout_amisha         (dout),
    .rx_done_tick_amisha (done),
    .frame_err_amisha    (ferr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(negedge clk);
      if (s_tick) k++;
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    wait_ticks(OS);
  endtask

  // Expected result of a frame is just its byte plus whether the stop bit was low.
  task automatic send_frame(input logic [7:0] data, input logic stop);
    exp_q.push_back({~stop, data});
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    drive_bit(stop);
    if (!stop) drive_bit(1'b1);
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("frame_dout", 32'(dout), 32'(e[7:0]));
        check("frame_err", 32'(ferr), 32'(e[8]));
        last_dout = e[7:0];
      end
    end else if (!rst && ferr) begin
      check("err_without_done", 32'(ferr), 32'd0);
    end
  end

  initial begin
    #(100 * 90000);
    $display("FAIL watchdog: simulation time limit reached, observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_dout", 32'(dout), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(ferr), 32'd0);
    rst = 1'b0;
    wait_ticks(2);

    send_frame(8'hA5, 1'b1);
    wait_ticks(4);

    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_ticks(4);

    // Short low pulse: rejected at mid start bit.
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(2 * OS);
    check("glitch_dout_held", 32'(dout), 32'(last_dout));
    check("glitch_no_pending", 32'(exp_q.size()), 32'd0);

    send_frame(8'h3C, 1'b0);
    wait_ticks(4);

    // Reset partway through 0x5A: outputs clear at once and no frame is reported.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h5A >> i));
    rst = 1'b1;
    #1;
    check("midreset_dout", 32'(dout), 32'd0);
    check("midreset_done", 32'(done), 32'd0);
    check("midreset_err", 32'(ferr), 32'd0);
    last_dout = 8'h00;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_ticks(2 * OS);
    send_frame(8'h81, 1'b1);
    wait_ticks(4);

    // Break: one all-zero frame with error, nothing more while the line stays low.
    exp_q.push_back({1'b1, 8'h00});
    rx = 1'b0;
    wait_ticks(14 * OS);
    check("break_consumed", 32'(exp_q.size()), 32'd0);
    rx = 1'b1;
    wait_ticks(OS);
    send_frame(8'h96, 1'b1);
    wait_ticks(4);

    for (int f = 0; f < 4; f++) begin
      logic [7:0] d;
      logic       sb;
      d  = 8'($urandom_range(0, 255));
      sb = ($urandom_range(0, 3) != 0);
      send_frame(d, sb);
    end
    wait_ticks(4);

    // Tick high every clock: exact start-edge-to-done latency.
    @(negedge clk);
    tick_force = 1'b1;
    repeat (4) @(negedge clk);
    fork
      send_frame(8'hC3, 1'b1);
      begin
        repeat (LAT - 1) @(negedge clk);
        check("lat_done_early", 32'(done), 32'd0);
        @(negedge clk);
        check("lat_done", 32'(done), 32'd1);
        check("lat_dout", 32'(dout), 32'hC3);
      end
    join
    repeat (4) @(negedge clk);
    tick_force = 1'b0;
    wait_ticks(OS);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
